// File: rtl/text_pkg.sv
// Shared definitions for the text-mode renderer.
//  - Glyph cell geometry (8x16), RGB565 word width, default colours.
//  - Char buffer address width and the cell-address helper.
//  - Frame FSM state encoding.
package text_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int RGB565_W = 16;
  localparam int ADDR_W   = 10;

  localparam logic [RGB565_W-1:0] DEFAULT_FG = 16'hFFFF;
  localparam logic [RGB565_W-1:0] DEFAULT_BG = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Char buffer address of the cell covering pixel (x, y) on a grid of
  // 'cols' cells per text row. Divisions are by powers of two.
  function automatic logic [ADDR_W-1:0] cell_addr(input int x, input int y, input int cols);
    return ADDR_W'((y / CHAR_H) * cols + (x / CHAR_W));
  endfunction

endpackage

// File: rtl/text_raster_counter.sv
// Raster x/y coordinate counter.
//  clk, reset : clock, synchronous active-high reset
//  en         : advance one pixel (x inner, y outer)
//  clr        : return to (0,0)
//  x, y       : current coordinate
//  last       : current coordinate is the final pixel of the frame
// At the final pixel the counter saturates; it never wraps past the last row.
module text_raster_counter
  import text_pkg::*;
#(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240,
  localparam int XW = $clog2(H_PIXELS),
  localparam int YW = $clog2(V_PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic x_end;

  assign x_end = (x == XW'(H_PIXELS - 1));
  assign last  = x_end && (y == YW'(V_PIXELS - 1));

  // NOTE: registered state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (en && !last) begin
      if (x_end) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/text_pixel_streamer.sv
// Text-mode frame renderer: rasters an H x V frame, fetches the character
// code for each pixel from an external char RAM, looks the glyph bit up in an
// external char ROM and streams one RGB565 word per pixel (valid/ready).
//  i_clk, i_reset     : clock, synchronous active-high reset
//  i_start            : frame start request (ignored while busy / on frame_done)
//  o_busy             : frame in progress
//  o_char_addr        : char RAM address; i_char_data returns one cycle later
//  o_rom_col/row/ascii: char ROM inputs; i_rom_pixel returns one cycle later
//  o_px_data/valid    : pixel stream, accepted when valid & i_px_ready
//  o_px_last          : marks pixel (H-1, V-1)
//  o_frame_done       : one-cycle pulse after the last pixel is accepted
// Pipeline: A = RAM address, B = ROM inputs, C = ROM bit returns, D = output.
module text_pixel_streamer
  import text_pkg::*;
#(
  parameter int                  H_PIXELS = 320,
  parameter int                  V_PIXELS = 240,
  parameter logic [RGB565_W-1:0] FG_COLOR = DEFAULT_FG,
  parameter logic [RGB565_W-1:0] BG_COLOR = DEFAULT_BG
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_busy,
  output logic [ADDR_W-1:0]   o_char_addr,
  input  logic [7:0]          i_char_data,
  output logic [2:0]          o_rom_col,
  output logic [3:0]          o_rom_row,
  output logic [7:0]          o_rom_ascii,
  input  logic                i_rom_pixel,
  output logic [RGB565_W-1:0] o_px_data,
  output logic                o_px_valid,
  input  logic                i_px_ready,
  output logic                o_px_last,
  output logic                o_frame_done
);

  localparam int COLS = H_PIXELS / CHAR_W;
  localparam int XW   = $clog2(H_PIXELS);
  localparam int YW   = $clog2(V_PIXELS);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          cnt_last;
  logic          adv, accept, start_ok, issue;

  logic          a_valid, a_last;
  logic [2:0]    a_col;
  logic [3:0]    a_row;
  logic          b_valid, b_last;
  logic          c_valid, c_last;

  logic          adv_q;
  logic [7:0]    char_hold;
  logic          pix_hold;
  logic          pix_bit;

  assign adv      = !o_px_valid || i_px_ready;
  assign accept   = o_px_valid && i_px_ready;
  assign start_ok = (state == IDLE) && i_start && !o_frame_done;
  assign issue    = adv && (start_ok || (state == RUN));

  // The external RAM/ROM re-sample the held addresses during a stall, so
  // after the first stalled cycle their outputs belong to the next stage.
  // The value seen on the last advancing edge is kept and replayed instead.
  assign o_rom_ascii = adv_q ? i_char_data : char_hold;
  assign pix_bit     = adv_q ? i_rom_pixel : pix_hold;

  text_raster_counter #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_counter (
    .clk   (i_clk),
    .reset (i_reset),
    .en    (issue),
    .clr   (state == DRAIN),
    .x     (x),
    .y     (y),
    .last  (cnt_last)
  );

  // Frame FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            o_busy <= 1'b1;
            if (cnt_last) state <= DRAIN;
            else          state <= RUN;
          end
        end
        RUN: begin
          if (issue && cnt_last) state <= DRAIN;
        end
        DRAIN: begin
          if (accept && o_px_last) begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel pipeline; every stage moves together when the output can advance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_char_addr <= '0;
      a_valid     <= 1'b0;
      a_last      <= 1'b0;
      a_col       <= '0;
      a_row       <= '0;
      b_valid     <= 1'b0;
      b_last      <= 1'b0;
      o_rom_col   <= '0;
      o_rom_row   <= '0;
      c_valid     <= 1'b0;
      c_last      <= 1'b0;
      o_px_valid  <= 1'b0;
      o_px_last   <= 1'b0;
      o_px_data   <= BG_COLOR;
      adv_q       <= 1'b0;
      char_hold   <= '0;
      pix_hold    <= 1'b0;
    end else begin
      adv_q     <= adv;
      char_hold <= o_rom_ascii;
      pix_hold  <= pix_bit;
      if (adv) begin
        a_valid <= issue;
        a_last  <= issue && cnt_last;
        if (issue) begin
          o_char_addr <= cell_addr(int'(x), int'(y), COLS);
          a_col       <= x[2:0];
          a_row       <= y[3:0];
        end
        b_valid    <= a_valid;
        b_last     <= a_last;
        o_rom_col  <= a_col;
        o_rom_row  <= a_row;
        c_valid    <= b_valid;
        c_last     <= b_last;
        o_px_valid <= c_valid;
        o_px_last  <= c_last;
        if (c_valid) o_px_data <= pix_bit ? FG_COLOR : BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_streamer.sv
// Self-checking bench for text_pixel_streamer (320x32 frame to keep runs short;
// 40 columns so cell addresses match the full-size layout).
module tb_text_pixel_streamer;
  import text_pkg::*;

  localparam int          H    = 320;
  localparam int          V    = 32;
  localparam int          COLS = H / 8;
  localparam int          NPIX = H * V;
  localparam logic [15:0] FG   = 16'hFFFF;
  localparam logic [15:0] BG   = 16'h0000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_px_ready = 1'b1;
  logic        o_busy, o_px_valid, o_px_last, o_frame_done;
  logic [9:0]  o_char_addr;
  logic [2:0]  o_rom_col;
  logic [3:0]  o_rom_row;
  logic [7:0]  o_rom_ascii;
  logic [15:0] o_px_data;
  logic [7:0]  ram_q;
  logic        rom_q;

  logic [7:0]  ram [0:1023];
  logic [15:0] got [0:NPIX-1];

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_idx = 0;
  bit          done_due = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  text_pixel_streamer #(
    .H_PIXELS (H),
    .V_PIXELS (V),
    .FG_COLOR (FG),
    .BG_COLOR (BG)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_char_addr  (o_char_addr),
    .i_char_data  (ram_q),
    .o_rom_col    (o_rom_col),
    .o_rom_row    (o_rom_row),
    .o_rom_ascii  (o_rom_ascii),
    .i_rom_pixel  (rom_q),
    .o_px_data    (o_px_data),
    .o_px_valid   (o_px_valid),
    .i_px_ready   (i_px_ready),
    .o_px_last    (o_px_last),
    .o_frame_done (o_frame_done)
  );

  // Glyph table of the external char ROM: space blank, 0xDB solid block,
  // anything else a code-dependent checker pattern.
  function automatic logic glyph(input logic [7:0] a, input logic [3:0] row, input logic [2:0] col);
    if (a == 8'h20) return 1'b0;
    if (a == 8'hDB) return 1'b1;
    return 1'((int'(a) >> col) + int'(row));
  endfunction

  // External registered char RAM and char ROM, one cycle latency each.
  always @(posedge clk) begin
    ram_q <= ram[o_char_addr];
    rom_q <= glyph(o_rom_ascii, o_rom_row, o_rom_col);
  end

  // Expected colour of the n-th pixel in raster order.
  function automatic logic [15:0] model_px(input int n);
    int px = n % H;
    int py = n / H;
    logic [7:0] ch = ram[(py / 16) * COLS + px / 8];
    return glyph(ch, 4'(py % 16), 3'(px % 8)) ? FG : BG;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted pixel against the model, stall stability,
  // and frame_done exactly one cycle after the last pixel is accepted.
  initial forever begin
    @(negedge clk);
    if (i_reset) begin
      exp_idx    = 0;
      done_due   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("frame_done_timing", 32'(o_frame_done), 32'(done_due));
      done_due = 1'b0;
      if (stall_prev) begin
        check("stall_valid", 32'(o_px_valid), 1);
        check("stall_data", 32'(o_px_data), 32'(prev_data));
        check("stall_last", 32'(o_px_last), 32'(prev_last));
      end
      if (o_px_valid && i_px_ready) begin
        check("px_data", 32'(o_px_data), 32'(model_px(exp_idx)));
        check("px_last", 32'(o_px_last), 32'(exp_idx == NPIX - 1));
        got[exp_idx] = o_px_data;
        if (exp_idx == NPIX - 1) begin
          done_due = 1'b1;
          exp_idx  = 0;
        end else begin
          exp_idx++;
        end
      end
      stall_prev = o_px_valid && !i_px_ready;
      prev_data  = o_px_data;
      prev_last  = o_px_last;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Called just after the edge that samples an accepted start.
  task automatic expect_first_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, "_busy"}, 32'(o_busy), 1);
    end while (!o_px_valid && n < 20);
    check({name, "_latency"}, n, 4);
  endtask

  task automatic start_pulse(input string name);
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    expect_first_valid(name);
  endtask

  // Runs until frame_done is seen at a falling edge (returns there).
  task automatic run_frame(input bit rand_ready, input int budget);
    int c = 0;
    while (!o_frame_done && c < budget) begin
      @(posedge clk); #1;
      i_px_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      c++;
    end
    check("frame_done_seen", 32'(o_frame_done), 1);
  endtask

  initial begin
    int c;
    for (int k = 0; k < 1024; k++) ram[k] = 8'h20;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_px_valid), 0);
    check("rst_last", 32'(o_px_last), 0);
    check("rst_done", 32'(o_frame_done), 0);
    check("rst_data", 32'(o_px_data), 32'(BG));
    check("rst_addr", 32'(o_char_addr), 0);
    check("rst_rom", {21'd0, o_rom_col, o_rom_row, o_rom_ascii}, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // Frame A: blank buffer, ready held high
    start_pulse("A");
    run_frame(1'b0, NPIX + 100);
    check("A_last_px", 32'(got[NPIX-1]), 32'(BG));

    // Frame B: solid block in cell 0, letters elsewhere; starts mid-frame ignored
    for (int k = 0; k < 1024; k++)
      ram[k] = (k == 0) ? 8'hDB : (k == 1) ? 8'h20 : 8'(8'h41 + k % 26);
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (c = 1; c <= NPIX + 50; c++) begin
      @(negedge clk);
      if (c == 2)    check("B_ascii_p0", 32'(o_rom_ascii), 32'h0DB);
      if (c == 3)    check("B_c3_invalid", 32'(o_px_valid), 0);
      if (c == 4)    check("B_c4_valid", 32'(o_px_valid), 1);
      if (c == 9)    check("B_addr_x8", 32'(o_char_addr), 1);
      if (c == 9)    check("B_col_x7", 32'(o_rom_col), 7);
      if (c == 10)   check("B_ascii_x8", 32'(o_rom_ascii), 32'h020);
      if (c == 337)  check("B_row_y1", 32'(o_rom_row), 1);
      if (c == 5121) check("B_addr_y16", 32'(o_char_addr), 40);
      if (c == 2000 || c == 7000) i_start = 1'b1;
      if (c == 2001 || c == 7001) i_start = 1'b0;
      if (o_frame_done) break;
    end
    check("B_done_cycle", c, NPIX + 4);
    check("B_px_0_0", 32'(got[0]), 32'(FG));
    check("B_px_7_15", 32'(got[15 * H + 7]), 32'(FG));
    check("B_px_8_0", 32'(got[8]), 32'(BG));
    check("B_px_16_0", 32'(got[16]), 32'(FG));
    check("B_px_18_0", 32'(got[18]), 32'(BG));
    check("B_px_16_1", 32'(got[H + 16]), 32'(BG));

    // Start in the frame_done cycle is ignored; held into the next cycle it is taken
    i_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("C_start_on_done_ignored", 32'(o_busy), 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    expect_first_valid("C");

    // Frame C: random back-pressure
    run_frame(1'b1, 4 * NPIX);
    @(posedge clk); #1;
    i_px_ready = 1'b1;

    // Frame D: reset while pixel 1000 is on the output
    start_pulse("D");
    repeat (1000) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("D_abort_valid", 32'(o_px_valid), 0);
    check("D_abort_busy", 32'(o_busy), 0);
    check("D_abort_addr", 32'(o_char_addr), 0);
    check("D_abort_data", 32'(o_px_data), 32'(BG));
    @(posedge clk); #1;
    i_reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("D_idle_after_abort", {30'd0, o_busy, o_frame_done}, 0);
    end

    // Frame E: full frame from (0,0), final pixel stalled 100 cycles
    start_pulse("E");
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!(o_px_valid && o_px_last) && c < NPIX + 50);
    i_px_ready = 1'b0;
    check("E_reached_last", 32'(o_px_last), 1);
    repeat (100) begin
      @(negedge clk);
      check("E_hold_last", {30'd0, o_px_valid, o_px_last}, 3);
      check("E_hold_busy", 32'(o_busy), 1);
    end
    @(posedge clk); #1;
    i_px_ready = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_frame_done && c < 10);
    check("E_done_after_accept", c, 2);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
